sign_trunc: RTL and testbench
=============================

# sign_trunc

Streaming narrower that converts 32-bit two's-complement words to 16-bit halfwords. It range-checks each word and flags values that do not fit the 16-bit signed range. It sits at the write/store side of the datapath, where 32-bit results are packed back into 16-bit immediate/halfword fields, and is the inverse of the 16→32 sign-extension path. It uses a valid/ready handshake on both sides with a two-entry skid buffer, so it can sit in a backpressured pipeline without bubbles.

## Interface
Parameters:
- IN_W, 32, input word width
- OUT_W, 16, output width; must satisfy OUT_W < IN_W
- CNT_W, 8, width of the overflow event counter

Ports:
- clk  in  1  single clock; everything on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input word present
- in_ready  out  1  block can accept a word this cycle
- in_data  in  IN_W  two's-complement input word
- out_valid  out  1  output halfword present
- out_ready  in  1  downstream accepts this cycle
- out_data  out  OUT_W  narrowed result
- out_ovf  out  1  travels with out_data; 1 = the source word was out of range
- clr  in  1  synchronous clear of ovf_sticky and ovf_count
- ovf_sticky  out  1  set by any accepted out-of-range word
- ovf_count  out  CNT_W  number of accepted out-of-range words; saturates at all-ones

## Operation
- Accept occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Range check: a word fits iff bits in_data[IN_W-1:OUT_W-1] are all 0 or all 1. ovf = !fits.
- Data when the word fits: out_data = in_data[OUT_W-1:0].
- Data on overflow, default (wrap): out_data = in_data[OUT_W-1:0].
- Data on overflow, saturation configured: out_data = 0x7FFF if in_data[IN_W-1]=0, else 0x8000 (generalised to OUT_W).
- Buffering: a main output register plus one skid register. Order is strictly preserved. No word is dropped or duplicated.
- in_ready is registered, and equals 0 whenever the skid register is occupied at the end of the cycle.
- ovf_sticky and ovf_count update on accept, not on output transfer. The counter holds at 2^CNT_W-1.
- clr together with an overflow accept in the same cycle: the clear is applied first, then the event counts. Result next cycle: ovf_count=1, ovf_sticky=1.
- clr without an accept: ovf_count=0, ovf_sticky=0 next cycle.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_ovf=0, ovf_sticky=0, ovf_count=0. in_ready rises in the first cycle after rst deasserts.
- rst asserted mid-stream: both buffer entries are discarded at the next edge, and all outputs return to their reset values. Accepts in the rst cycle are ignored.
- Latency: an accept in cycle N gives out_valid=1 with the corresponding data in cycle N+1, provided the output register is free.
- Throughput: one word per cycle with out_ready held high.
- When out_ready=0 and the main register is full, one further word is absorbed into the skid register and in_ready drops the following cycle.
- On out_ready returning to 1, the main register drains first and the skid register moves up. in_ready returns to 1 one cycle after the skid register empties.
- out_data and out_ovf are held stable while out_valid && !out_ready.

## Configuration
- SIGN_TRUNC_SAT_EN defined: out-of-range words are clamped to the signed extremes. out_ovf and the counters still report the event.
- SIGN_TRUNC_SAT_EN undefined: out-of-range words wrap (low OUT_W bits passed through), with flag and counters unchanged. No saturation logic is synthesised.

## Structure
- Package sign_trunc_pkg holds:
  - default IN_W, OUT_W and CNT_W constants
  - the sat_max/sat_min constant functions of OUT_W
  - the payload struct type {data, ovf} used inside the buffer
- Sub-module skid_buf: generic two-entry valid/ready register slice over the payload struct, with registered in_ready.
- sign_trunc instantiates skid_buf and holds the range check, the optional clamp, the sticky flag and the counter.

## Test plan
- Fits: inputs 0x00007FFF, 0xFFFF8000, 0x00000000, 0xFFFFFFFF with out_ready=1. Required: outputs 0x7FFF, 0x8000, 0x0000, 0xFFFF, all with out_ovf=0, each one cycle after its accept. ovf_count stays 0.
- Overflow, wrap build: inputs 0x00008000 and 0xFFFF7FFF. Required: outputs 0x8000 and 0x7FFF with out_ovf=1, ovf_count=2, ovf_sticky=1.
- Overflow, SIGN_TRUNC_SAT_EN build: inputs 0x00008000, 0x7FFFFFFF, 0xFFFF7FFF, 0x80000000. Required: outputs 0x7FFF, 0x7FFF, 0x8000, 0x8000, with out_ovf=1 on each.
- Backpressure: in_valid held high with values 1, 2, 3, 4, 5 while out_ready=0 for 4 cycles, then 1. Required: exactly 2 accepts before in_ready=0, outputs 1..5 in order with no loss, out_data stable while stalled.
- Counter: 260 overflow words accepted. Required: ovf_count=255. Then clr in the same cycle as an overflow accept gives ovf_count=1 and ovf_sticky=1. A following clr alone gives 0 and 0.
- Reset mid-stream: rst while both buffer entries are full. Required: next cycle out_valid=0, in_ready=0, ovf_count=0. The first post-reset word emerges alone and correct.

Source files
------------

// File: rtl/sign_trunc_pkg.sv
// Shared constants, saturation helpers and the buffered payload type for sign_trunc.
// The buffered payload is sized by DEF_OUT_W, so the top's OUT_W is expected to match it.
package sign_trunc_pkg;

  localparam int DEF_IN_W  = 32;
  localparam int DEF_OUT_W = 16;
  localparam int DEF_CNT_W = 8;

  // Largest positive value representable in a w-bit signed field.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative w-bit signed value, as its w-bit pattern (zero-extended).
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

  typedef struct packed {
    logic [DEF_OUT_W-1:0] data;
    logic                 ovf;
  } payload_t;

endpackage

// File: rtl/sign_trunc_skid_buf.sv
// Two-entry valid/ready register slice (main + skid) with a registered in_ready.
// Handshake: a beat moves on a side when its valid and ready are both 1 at a rising edge;
// a producer holding valid keeps its data stable until that edge.
module skid_buf
  import sign_trunc_pkg::*;
#(
  parameter type T = payload_t
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data,
  output logic skid_full
);

  logic m_valid;
  logic s_valid;
  logic s_valid_nxt;
  T     m_data;
  T     s_data;
  logic acc;
  logic main_free;

  assign acc       = in_valid && in_ready;
  assign main_free = !m_valid || out_ready;

  // in_ready mirrors !s_valid, so an accept never coincides with an occupied skid entry.
  always_comb begin
    s_valid_nxt = 1'b0;
    if (!main_free) s_valid_nxt = s_valid || acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid  <= 1'b0;
      s_valid  <= 1'b0;
      m_data   <= '0;
      s_data   <= '0;
      in_ready <= 1'b0;
    end else begin
      if (main_free) begin
        if (s_valid) begin
          m_data  <= s_data;
          m_valid <= 1'b1;
        end else if (acc) begin
          m_data  <= in_data;
          m_valid <= 1'b1;
        end else begin
          m_valid <= 1'b0;
        end
      end else if (acc) begin
        s_data <= in_data;
      end
      s_valid  <= s_valid_nxt;
      in_ready <= !s_valid_nxt;
    end
  end

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign skid_full = s_valid;

endmodule

// File: rtl/sign_trunc.sv
// 32->16 signed narrower with overflow flag, sticky bit and saturating event counter.
// Define SIGN_TRUNC_SAT_EN to clamp out-of-range words instead of wrapping them.
module sign_trunc
  import sign_trunc_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  input  logic             clr,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  logic [IN_W-OUT_W:0] upper;
  logic                fits;
  logic                ovf;
  logic [OUT_W-1:0]    narrowed;
  logic                acc;
  logic                skid_full;
  payload_t            in_pay;
  payload_t            out_pay;

  // The word fits when the dropped bits plus the new sign bit are all copies of one value.
  assign upper = in_data[IN_W-1:OUT_W-1];
  assign fits  = (&upper) || (~|upper);
  assign ovf   = !fits;

`ifdef SIGN_TRUNC_SAT_EN
  localparam logic [63:0] SAT_MAX_W = sat_max(OUT_W);
  localparam logic [63:0] SAT_MIN_W = sat_min(OUT_W);
  localparam logic [OUT_W-1:0] SAT_MAX = SAT_MAX_W[OUT_W-1:0];
  localparam logic [OUT_W-1:0] SAT_MIN = SAT_MIN_W[OUT_W-1:0];

  always_comb begin
    narrowed = in_data[OUT_W-1:0];
    if (ovf) narrowed = in_data[IN_W-1] ? SAT_MIN : SAT_MAX;
  end
`else
  assign narrowed = in_data[OUT_W-1:0];
`endif

  assign in_pay.data = narrowed;
  assign in_pay.ovf  = ovf;

  skid_buf #(.T(payload_t)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pay),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pay),
    .skid_full (skid_full)
  );

  assign out_data = out_pay.data;
  assign out_ovf  = out_pay.ovf;
  assign acc      = in_valid && in_ready;

  // A clear in the same cycle as an overflow accept wipes first, then counts the new event.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count  <= '0;
      ovf_sticky <= 1'b0;
    end else if (acc && ovf) begin
      ovf_sticky <= 1'b1;
      if (clr)             ovf_count <= CNT_W'(1);
      else if (!(&ovf_count)) ovf_count <= ovf_count + CNT_W'(1);
    end else if (clr) begin
      ovf_count  <= '0;
      ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sign_trunc.sv
// Directed + randomized bench for sign_trunc with a queue-based reference model.
module tb_sign_trunc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        clr = 1'b0;
  logic        ovf_sticky;
  logic [7:0]  ovf_count;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [16:0] exp_q[$];
  int          m_cnt = 0;
  bit          m_sticky = 1'b0;
  bit          held_v = 1'b0;
  logic [16:0] held_p = '0;

  always #5 clk = ~clk;

  sign_trunc dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .clr        (clr),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, halfword} from the signed value of the word.
  function automatic logic [16:0] model(input logic [31:0] w);
    int          v;
    bit          o;
    logic [15:0] d;
    v = $signed(w);
    o = (v > 32767) || (v < -32768);
    d = w[15:0];
`ifdef SIGN_TRUNC_SAT_EN
    if (v > 32767) d = 16'h7fff;
    else if (v < -32768) d = 16'h8000;
`endif
    return {o, d};
  endfunction

  function automatic bit is_ovf(input logic [31:0] w);
    logic [16:0] p;
    p = model(w);
    return p[16];
  endfunction

  // Scoreboard: sampled on the falling edge, while inputs and outputs are stable.
  always @(negedge clk) begin
    logic [16:0] e;
    if (chk_en) begin
      chk("ovf_count", {24'd0, ovf_count}, m_cnt);
      chk("ovf_sticky", {31'd0, ovf_sticky}, {31'd0, m_sticky});
      if (held_v && out_valid && !rst) chk("stall_hold", {15'd0, out_ovf, out_data}, {15'd0, held_p});
    end
    if (rst) begin
      exp_q.delete();
      m_cnt = 0;
      m_sticky = 1'b0;
      held_v = 1'b0;
    end else if (chk_en) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", {15'd0, out_ovf, out_data}, 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          chk("out_word", {15'd0, out_ovf, out_data}, {15'd0, e});
        end
      end
      held_v = out_valid && !out_ready;
      held_p = {out_ovf, out_data};
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data));
        if (is_ovf(in_data)) begin
          m_cnt = clr ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
          m_sticky = 1'b1;
        end else if (clr) begin
          m_cnt = 0;
          m_sticky = 1'b0;
        end
      end else if (clr) begin
        m_cnt = 0;
        m_sticky = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word; returns just after the edge that accepted it.
  task automatic send(input logic [31:0] w);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    in_data = w;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    step();
    in_valid = 1'b0;
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && (out_valid || exp_q.size() != 0); i++) step();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [31:0] rand_ovf_word();
    logic [31:0] w;
    w = $urandom;
    while (!is_ovf(w)) w = $urandom;
    return w;
  endfunction

  logic [31:0] fit_in[4]  = '{32'h0000_7fff, 32'hffff_8000, 32'h0000_0000, 32'hffff_ffff};
  logic [15:0] fit_out[4] = '{16'h7fff, 16'h8000, 16'h0000, 16'hffff};
`ifdef SIGN_TRUNC_SAT_EN
  localparam int NOV = 4;
  logic [31:0] ov_in[NOV]  = '{32'h0000_8000, 32'h7fff_ffff, 32'hffff_7fff, 32'h8000_0000};
  logic [15:0] ov_out[NOV] = '{16'h7fff, 16'h7fff, 16'h8000, 16'h8000};
`else
  localparam int NOV = 2;
  logic [31:0] ov_in[NOV]  = '{32'h0000_8000, 32'hffff_7fff};
  logic [15:0] ov_out[NOV] = '{16'h8000, 16'h7fff};
`endif

  initial begin
    int idx;
    int acc_stall;
    bit accepted;

    // Reset state
    repeat (3) step();
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", {16'd0, out_data}, 0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 0);
    chk_en = 1'b1;
    rst = 1'b0;
    step();
    chk("in_ready_after_rst", {31'd0, in_ready}, 1);

    // Words that fit, one cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(fit_in[i]);
      chk("fit_valid", {31'd0, out_valid}, 1);
      chk("fit_data", {16'd0, out_data}, {16'd0, fit_out[i]});
      chk("fit_ovf", {31'd0, out_ovf}, 0);
    end
    drain();
    chk("fit_count", {24'd0, ovf_count}, 0);

    // Out-of-range words
    for (int i = 0; i < NOV; i++) begin
      send(ov_in[i]);
      chk("ovf_data", {16'd0, out_data}, {16'd0, ov_out[i]});
      chk("ovf_flag", {31'd0, out_ovf}, 1);
    end
    drain();
    chk("ovf_count_dir", {24'd0, ovf_count}, NOV);
    chk("ovf_sticky_dir", {31'd0, ovf_sticky}, 1);

    // Backpressure: 4 stalled cycles, then release
    out_ready = 1'b0;
    idx = 1;
    acc_stall = 0;
    in_valid = 1'b1;
    in_data = 32'd1;
    for (int c = 0; c < 60 && idx <= 5; c++) begin
      if (c == 4) out_ready = 1'b1;
      @(negedge clk);
      accepted = in_ready;
      if (accepted && c < 4) acc_stall++;
      step();
      if (accepted) begin
        idx++;
        in_data = idx;
        if (idx > 5) in_valid = 1'b0;
      end
      if (c == 2) chk("bp_ready_low", {31'd0, in_ready}, 0);
    end
    in_valid = 1'b0;
    chk("bp_stall_accepts", acc_stall, 2);
    chk("bp_all_sent", idx, 6);
    drain();

    // Randomized stream with random backpressure
    clr = 1'b1;
    step();
    clr = 1'b0;
    begin
      int sent;
      sent = 0;
      in_valid = 1'b0;
      for (int c = 0; c < 2000 && sent < 300; c++) begin
        if (!in_valid) begin
          in_valid = ($urandom_range(0, 3) != 0);
          in_data = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom))) : $urandom;
        end
        out_ready = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        accepted = in_valid && in_ready;
        step();
        if (accepted) begin
          sent++;
          in_valid = 1'b0;
        end
      end
      in_valid = 1'b0;
      chk("rand_sent", sent, 300);
    end
    drain();

    // Counter saturation, then clear interplay
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 260; i++) send(rand_ovf_word());
    chk("cnt_sat", {24'd0, ovf_count}, 255);
    clr = 1'b1;
    send(rand_ovf_word());
    chk("clr_acc_count", {24'd0, ovf_count}, 1);
    chk("clr_acc_sticky", {31'd0, ovf_sticky}, 1);
    step();
    clr = 1'b0;
    chk("clr_only_count", {24'd0, ovf_count}, 0);
    chk("clr_only_sticky", {31'd0, ovf_sticky}, 0);
    drain();

    // Reset with both entries occupied
    out_ready = 1'b0;
    send(32'h0001_0000);
    send(32'h0002_0000);
    chk("pre_rst_ready", {31'd0, in_ready}, 0);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h0000_4444;
    step();
    in_valid = 1'b0;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 0);
    chk("mid_rst_count", {24'd0, ovf_count}, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    send(32'h0000_1234);
    chk("post_rst_valid", {31'd0, out_valid}, 1);
    chk("post_rst_data", {16'd0, out_data}, 32'h1234);
    step();
    chk("post_rst_alone", {31'd0, out_valid}, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
